// File: rtl/tick_sched_pkg.sv
// Shared constants and types for the tick scheduler.
package tick_sched_pkg;

    // Default build parameters.
    localparam int unsigned NCH      = 4;
    localparam int unsigned PW       = 16;
    localparam int unsigned BASE_DIV = 100000;

    typedef enum logic {
        MODE_PERIODIC,
        MODE_ONESHOT
    } tick_mode_e;

    // Channel assignment in the craps game.
    localparam int unsigned CH_DICE_ANIM = 0;
    localparam int unsigned CH_DISP_MUX  = 1;
    localparam int unsigned CH_DEBOUNCE  = 2;
    localparam int unsigned CH_GAME_SEC  = 3;

    // Default periods, in base ticks.
    localparam int unsigned PER_GAME_SEC = 1000;
    localparam int unsigned PER_DISP_MUX = 1;

    // Width of an index into n items, never below 1 bit.
    function automatic int unsigned idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: period/count/busy state and a registered tick pulse.
// Optional one-shot mode is compiled in with TICK_SCHED_ONESHOT_EN.
module tick_channel #(
    parameter int unsigned PW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          update_i,
    input  logic          cfg_we_i,
    input  logic [PW-1:0] cfg_period_i,
    input  logic          cfg_oneshot_i,
    input  logic          en_i,
    output logic          tick_o,
    output logic          busy_o
);
    import tick_sched_pkg::*;

    logic [PW-1:0] period_q, period_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          armed;
    logic          step;
    logic          oneshot;

`ifdef TICK_SCHED_ONESHOT_EN
    tick_mode_e mode_q, mode_d;
    logic       busy_q, busy_d;

    assign armed   = busy_q;
    assign oneshot = (mode_q == MODE_ONESHOT);
`else
    logic unused_oneshot;

    // Every channel is periodic, so "armed" is simply a non-zero period.
    assign unused_oneshot = cfg_oneshot_i;
    assign armed          = (period_q != '0);
    assign oneshot        = 1'b0;
`endif

    assign step = update_i && armed && en_i;

    // Next-state: config load wins, otherwise count down on enabled update cycles.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
        mode_d   = mode_q;
        busy_d   = busy_q;
`endif
        if (cfg_we_i) begin
            period_d = cfg_period_i;
            cnt_d    = cfg_period_i;
`ifdef TICK_SCHED_ONESHOT_EN
            mode_d   = cfg_oneshot_i ? MODE_ONESHOT : MODE_PERIODIC;
            busy_d   = (cfg_period_i != '0);
`endif
        end else if (step) begin
            if (cnt_q == PW'(1)) begin
                tick_d = 1'b1;
                if (oneshot) begin
                    cnt_d = '0;
`ifdef TICK_SCHED_ONESHOT_EN
                    busy_d = 1'b0;
`endif
                end else begin
                    cnt_d = period_q;
                end
            end else begin
                cnt_d = cnt_q - PW'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            period_q <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
            mode_q   <= MODE_PERIODIC;
            busy_q   <= 1'b0;
`endif
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
`ifdef TICK_SCHED_ONESHOT_EN
            mode_q   <= mode_d;
            busy_q   <= busy_d;
`endif
        end
    end

    assign tick_o = tick_q;
    assign busy_o = armed;

endmodule

// File: rtl/tick_scheduler.sv
// Shared tick source: a prescaler producing a base tick, plus NCH programmable
// channels emitting single-cycle clock-enable pulses.
// Optional one-shot mode: define TICK_SCHED_ONESHOT_EN.
module tick_scheduler #(
    parameter int unsigned BASE_DIV = tick_sched_pkg::BASE_DIV,
    parameter int unsigned NCH      = tick_sched_pkg::NCH,
    parameter int unsigned PW       = tick_sched_pkg::PW
) (
    input  logic                                 cin_i,
    input  logic                                 rst_ni,
    input  logic                                 cfg_valid_i,
    output logic                                 cfg_ready_o,
    input  logic [tick_sched_pkg::idx_w(NCH)-1:0] cfg_ch_i,
    input  logic [PW-1:0]                        cfg_period_i,
    input  logic                                 cfg_oneshot_i,
    input  logic [NCH-1:0]                       ch_en_i,
    output logic                                 base_tick_o,
    output logic [NCH-1:0]                       tick_o,
    output logic [NCH-1:0]                       busy_o
);
    import tick_sched_pkg::*;

    localparam int unsigned CW    = idx_w(NCH);
    localparam int unsigned PRE_W = $clog2(BASE_DIV);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             base_tick_q, base_tick_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             pre_wrap;
    logic             cfg_xfer;

    assign pre_wrap = (pre_q == PRE_W'(BASE_DIV - 1));

    // Prescaler next-state; ready is dropped for exactly the update cycle.
    always_comb begin
        pre_d       = pre_wrap ? '0 : pre_q + PRE_W'(1);
        base_tick_d = pre_wrap;
        cfg_ready_d = !pre_wrap;
    end

    // Prescaler and handshake registers with synchronous active-low reset.
    always_ff @(posedge cin_i) begin
        if (!rst_ni) begin
            pre_q       <= '0;
            base_tick_q <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            base_tick_q <= base_tick_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    // Ready is low in every update cycle, so a config write never collides
    // with a channel update.
    assign cfg_xfer    = cfg_valid_i && cfg_ready_q;
    assign cfg_ready_o = cfg_ready_q;
    assign base_tick_o = base_tick_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic cfg_we;

        assign cfg_we = cfg_xfer && (cfg_ch_i == CW'(g));

        tick_channel #(
            .PW (PW)
        ) u_ch (
            .clk_i         (cin_i),
            .rst_ni        (rst_ni),
            .update_i      (base_tick_q),
            .cfg_we_i      (cfg_we),
            .cfg_period_i  (cfg_period_i),
            .cfg_oneshot_i (cfg_oneshot_i),
            .en_i          (ch_en_i[g]),
            .tick_o        (tick_o[g]),
            .busy_o        (busy_o[g])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler with BASE_DIV = 4.
module tb_tick_scheduler;

    localparam int unsigned BD  = 4;
    localparam int unsigned NCH = 4;
    localparam int unsigned PW  = 16;
`ifdef TICK_SCHED_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    logic           cin = 1'b0;
    logic           rst_n;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [PW-1:0]  cfg_period;
    logic           cfg_oneshot;
    logic [NCH-1:0] ch_en;
    logic           base_tick;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;

    always #5 cin = ~cin;

    tick_scheduler #(
        .BASE_DIV (BD),
        .NCH      (NCH),
        .PW       (PW)
    ) dut (
        .cin_i         (cin),
        .rst_ni        (rst_n),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_ch_i      (cfg_ch),
        .cfg_period_i  (cfg_period),
        .cfg_oneshot_i (cfg_oneshot),
        .ch_en_i       (ch_en),
        .base_tick_o   (base_tick),
        .tick_o        (tick),
        .busy_o        (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: c = cycles since reset release; channel state as integers.
    int             c = 0;
    int             m_rem [NCH];
    int             m_per [NCH];
    bit             m_os  [NCH];
    bit             m_arm [NCH];
    logic [NCH-1:0] m_tick = '0;
    bit             chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit bt, input bit rdy);
        logic [NCH-1:0] nt;
        int k;
        nt = '0;
        if (!rst_n) begin
            c = 0;
            for (int i = 0; i < NCH; i++) begin
                m_rem[i] = 0; m_per[i] = 0; m_os[i] = 0; m_arm[i] = 0;
            end
            m_tick = '0;
            return;
        end
        if (bt) begin
            for (int i = 0; i < NCH; i++) begin
                if (m_arm[i] && ch_en[i]) begin
                    if (m_rem[i] == 1) begin
                        nt[i] = 1'b1;
                        if (m_os[i]) begin
                            m_arm[i] = 0;
                            m_rem[i] = 0;
                        end else begin
                            m_rem[i] = m_per[i];
                        end
                    end else begin
                        m_rem[i] = m_rem[i] - 1;
                    end
                end
            end
        end
        if (cfg_valid && rdy) begin
            k = int'(cfg_ch);
            m_per[k] = int'(cfg_period);
            m_rem[k] = int'(cfg_period);
            m_os[k]  = ONESHOT && cfg_oneshot;
            m_arm[k] = (cfg_period != '0);
        end
        m_tick = nt;
        c++;
    endtask

    // Compare this cycle against the model, advance the model, move to next cycle.
    task automatic step_cycle();
        bit eb, er;
        logic [NCH-1:0] ebusy;
        eb = (c > 0) && (c % int'(BD) == 0);
        er = (c > 0) && !eb;
        for (int i = 0; i < NCH; i++) ebusy[i] = m_arm[i];
        if (chk_en) begin
            check("base_tick", 32'(base_tick), 32'(eb));
            check("cfg_ready", 32'(cfg_ready), 32'(er));
            check("tick", 32'(tick), 32'(m_tick));
            check("busy", 32'(busy), 32'(ebusy));
        end
        model_step(eb, er);
        @(posedge cin);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) step_cycle();
        rst_n = 1'b1;
    endtask

    // Move to the cycle just after a base_tick (ready is high there).
    task automatic align();
        int w;
        w = 0;
        while (base_tick !== 1'b1 && w < 10) begin
            step_cycle();
            w++;
        end
        check("align_timeout", 32'(base_tick), 32'd1);
        step_cycle();
    endtask

    task automatic cfg(input int ch, input int per, input bit os);
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_period = PW'(per); cfg_oneshot = os;
        step_cycle();
        idle_inputs();
    endtask

    typedef struct {
        int ch;
        int per;
        bit os;
        int first;
        int count;
    } vec_t;

    vec_t           tbl [6];
    int             first, cnt, k;
    logic [NCH-1:0] acc;
    logic [NCH-1:0] busy_acc;

    initial begin
        // Config applied one cycle after base_tick: first tick at offset P*BD.
        tbl[0] = '{0, 3, 1'b0, 12, 3};
        tbl[1] = '{1, 2, 1'b1, 8, (ONESHOT ? 1 : 5)};
        tbl[2] = '{2, 1, 1'b0, 4, 10};
        tbl[3] = '{3, 0, 1'b0, -1, 0};
        tbl[4] = '{3, 1000, 1'b0, -1, 0};
        tbl[5] = '{2, 5, 1'b1, 20, (ONESHOT ? 1 : 2)};

        rst_n = 1'b0;
        ch_en = '0;
        idle_inputs();
        step_cycle();
        chk_en = 1'b1;

        // Idle after reset: first base tick, then quiet channels.
        do_reset();
        k = 0;
        while (base_tick !== 1'b1 && k < 10) begin
            step_cycle();
            k++;
        end
        check("first_base_tick", 32'(k), 32'd4);
        acc = '0; busy_acc = '0;
        repeat (20) begin
            acc |= tick; busy_acc |= busy;
            step_cycle();
        end
        check("idle_tick", 32'(acc), 32'd0);
        check("idle_busy", 32'(busy_acc), 32'd0);

        // Table-driven single-channel scenarios.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            ch_en = '1;
            align();
            cfg(tbl[t].ch, tbl[t].per, tbl[t].os);
            first = -1; cnt = 0;
            for (int off = 1; off <= 40; off++) begin
                if (tick[tbl[t].ch]) begin
                    if (first < 0) first = off;
                    cnt++;
                end
                step_cycle();
            end
            check($sformatf("tbl%0d_first", t), 32'(first), 32'(tbl[t].first));
            check($sformatf("tbl%0d_count", t), 32'(cnt), 32'(tbl[t].count));
        end

        // Freeze: P=5, two updates, disabled for three, then three more to tick.
        do_reset();
        ch_en = '1;
        align();
        cfg(0, 5, 1'b0);
        first = -1;
        for (int off = 1; off <= 40; off++) begin
            if (off == 8)  ch_en[0] = 1'b0;
            if (off == 20) ch_en[0] = 1'b1;
            if (tick[0] && first < 0) first = off;
            step_cycle();
        end
        check("freeze_first", 32'(first), 32'd32);

        // Request on a base_tick cycle waits one cycle; then mid-count reconfig.
        do_reset();
        ch_en = '1;
        k = 0;
        while (base_tick !== 1'b1 && k < 10) begin
            step_cycle();
            k++;
        end
        check("rc_align", 32'(base_tick), 32'd1);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_period = PW'(4); cfg_oneshot = 1'b0;
        check("ready_on_base", 32'(cfg_ready), 32'd0);
        step_cycle();
        check("ready_after_base", 32'(cfg_ready), 32'd1);
        step_cycle();
        idle_inputs();
        repeat (7) step_cycle();
        cfg(2, 1, 1'b0);
        first = -1;
        for (int off = 9; off <= 16; off++) begin
            if (tick[2] && first < 0) first = off;
            step_cycle();
        end
        check("reconfig_first", 32'(first), 32'd12);

        // Coincident ticks, then reset mid-run.
        do_reset();
        ch_en = '1;
        align();
        cfg(0, 2, 1'b0);
        cfg(3, 2, 1'b0);
        repeat (6) step_cycle();
        check("coincident", 32'(tick), 32'b1001);
        step_cycle();
        step_cycle();
        rst_n = 1'b0;
        step_cycle();
        check("reset_outputs", 32'({base_tick, cfg_ready, tick, busy}), 32'd0);
        rst_n = 1'b1;
        acc = '0;
        repeat (40) begin
            acc |= tick;
            step_cycle();
        end
        check("no_tick_after_reset", 32'(acc), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        ch_en = '1;
        for (int n = 0; n < 3000; n++) begin
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_ch      = 2'($urandom_range(0, 3));
            cfg_period  = PW'($urandom_range(0, 6));
            cfg_oneshot = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) ch_en = NCH'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
            step_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
